// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-port data memory.
// Handles byte/halfword/word loads with extension and sub-word stores by read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wEn,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Only the addressed lane is replaced; the rest of the sampled word is written back untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (f3)
      F3_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_wen_q, mem_wen_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;

  logic accept_s;
  logic err_s;

  assign accept_s = req_valid & (state_q == IDLE);
  assign err_s    = req_illegal(req_we, req_funct3, req_addr[1:0]);

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      funct3_q         <= 3'b000;
      addr_q           <= 16'h0000;
      wdata_q          <= 32'h0000_0000;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0000_0000;
      mem_wen_q        <= 1'b0;
      mem_address_q    <= 16'h0000;
      mem_write_data_q <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      funct3_q         <= funct3_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_wen_q        <= mem_wen_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Request capture: inputs are only looked at on acceptance.
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (accept_s) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end else begin
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
    end
  end

  // Next-state: full-word stores skip the read, sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (err_s) begin
          state_d = RESP;
        end else if (req_we && (req_funct3 == F3_W)) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the state being entered so they can be registered.
  always_comb begin
    req_ready_d      = (state_d == IDLE);
    mem_wen_d        = (state_d == WRITE);
    resp_valid_d     = (state_d == RESP);
    resp_err_d       = (state_d == RESP) && (state_q == IDLE);
    mem_address_d    = 16'h0000;
    mem_write_data_d = 32'h0000_0000;
    resp_rdata_d     = 32'h0000_0000;
    if ((state_d == READ) || (state_d == WRITE)) begin
      mem_address_d = {addr_d[15:2], 2'b00};
    end else begin
      mem_address_d = 16'h0000;
    end
    if ((state_d == WRITE) && (state_q == READ)) begin
      mem_write_data_d = store_merge(mem_read_data, wdata_q, funct3_q, addr_q[1:0]);
    end else if (state_d == WRITE) begin
      mem_write_data_d = wdata_d;
    end else begin
      mem_write_data_d = 32'h0000_0000;
    end
    if ((state_d == RESP) && (state_q == READ)) begin
      resp_rdata_d = load_extract(mem_read_data, funct3_q, addr_q[1:0]);
    end else begin
      resp_rdata_d = 32'h0000_0000;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_wEn        = mem_wen_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

  load_store_unit_checker u_checker (
    .clk            (clk),
    .rst            (rst),
    .req_ready      (req_ready_q),
    .resp_valid     (resp_valid_q),
    .resp_err       (resp_err_q),
    .resp_rdata     (resp_rdata_q),
    .mem_wEn        (mem_wen_q),
    .mem_address    (mem_address_q),
    .mem_write_data (mem_write_data_q)
  );

endmodule

// Protocol properties of the load/store unit outputs.
module load_store_unit_checker (
  input logic        clk,
  input logic        rst,
  input logic        req_ready,
  input logic        resp_valid,
  input logic        resp_err,
  input logic [31:0] resp_rdata,
  input logic        mem_wEn,
  input logic [15:0] mem_address,
  input logic [31:0] mem_write_data
);

  a_wen_single: assert property (@(posedge clk) disable iff (!rst) mem_wEn |=> !mem_wEn);
  a_resp_single: assert property (@(posedge clk) disable iff (!rst) resp_valid |=> !resp_valid);
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst)
                                 req_ready |-> (!resp_valid && !mem_wEn));
  a_err_zero: assert property (@(posedge clk) disable iff (!rst)
                               resp_err |-> (resp_valid && (resp_rdata == 32'h0000_0000)));
  a_wdata_quiet: assert property (@(posedge clk) disable iff (!rst)
                                  !mem_wEn |-> (mem_write_data == 32'h0000_0000));
  a_wen_aligned: assert property (@(posedge clk) disable iff (!rst)
                                  mem_wEn |-> (mem_address[1:0] == 2'b00));

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abort sequence,
// and random transactions against a byte-lane reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wEn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h00;
  logic [31:0] pre_val = 32'h0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [15:0] wr_addr = 16'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_wEn        (mem_wEn),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:2]];

  // Memory model plus write/response monitors.
  always @(posedge clk) begin
    if (mem_wEn) begin
      mem[mem_address[9:2]] <= mem_write_data;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_address;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preset(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Reference: decode size/signedness, then operate on the word with shifts and masks.
  task automatic model(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [31:0] old,
                       output logic err, output logic [31:0] rd,
                       output logic [31:0] nw, output int lat);
    int size; bit sgn; bit illegal; int sh; longint mask; longint val;
    size = 1; sgn = 0; illegal = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: illegal = 1;
    endcase
    err = illegal || (int'(addr) % size != 0) || (we && (f3 == 3'd4 || f3 == 3'd5));
    sh = 8 * (int'(addr) % 4);
    mask = (64'd1 << (8 * size)) - 64'd1;
    rd = 32'h0; nw = old;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      val = (longint'(old) >> sh) & mask;
      if (sgn && val[8*size-1]) val = val | ~mask;
      rd = val[31:0];
      lat = 2;
    end else begin
      val = (longint'(old) & ~(mask << sh)) | ((longint'(wd) << sh) & (mask << sh));
      nw = val[31:0];
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  // One transaction; in-flight request inputs are scrambled to show they are ignored.
  task automatic exec(input string name, input logic we, input logic [2:0] f3,
                      input logic [15:0] addr, input logic [31:0] wd, input logic exp_err,
                      input logic [31:0] exp_rd, input logic [31:0] exp_word, input int exp_lat);
    int w0; bit found; int lat; logic got_err; logic [31:0] got_rd;
    w0 = wr_cnt; found = 0; lat = 0; got_err = 1'b0; got_rd = 32'h0;
    @(negedge clk);
    chk({name, " ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7)); req_addr = 16'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 8 && !found; c++) begin
      @(negedge clk);
      if (c == 1 && !exp_err)
        chk({name, " mem_address"}, {16'h0, mem_address}, {16'h0, addr[15:2], 2'b00});
      if (resp_valid) begin
        found = 1; lat = c; got_err = resp_err; got_rd = resp_rdata;
        chk({name, " ready_in_resp"}, {31'h0, req_ready}, 32'd0);
      end
    end
    req_valid = 1'b0;
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s timeout got no resp_valid expected one within 8 cycles", name);
    end else begin
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " resp_err"}, {31'h0, got_err}, {31'h0, exp_err});
      chk({name, " resp_rdata"}, got_rd, exp_rd);
    end
    chk({name, " mem_word"}, mem[addr[9:2]], exp_word);
    chk({name, " writes"}, wr_cnt - w0, (exp_err || !we) ? 0 : 1);
    if (we && !exp_err)
      chk({name, " wr_addr"}, {16'h0, wr_addr}, {16'h0, addr[15:2], 2'b00});
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] pre;
    logic        err;
    logic [31:0] rd;
    logic [31:0] word;
    int          lat;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic e; logic [31:0] r; logic [31:0] w; int l;
    logic we; logic [2:0] f3; logic [15:0] a; logic [31:0] wd;
    vt[0]  = '{"sw_006c",  1'b1, 3'd2, 16'h006c, 32'h11100011, 32'hDEADBEEF, 1'b0, 32'h0,        32'h11100011, 2};
    vt[1]  = '{"sb_006d",  1'b1, 3'd0, 16'h006d, 32'h000000AB, 32'h11100011, 1'b0, 32'h0,        32'h1110AB11, 3};
    vt[2]  = '{"lb_006e",  1'b0, 3'd0, 16'h006e, 32'h0,        32'h1180AB11, 1'b0, 32'hFFFFFF80, 32'h1180AB11, 2};
    vt[3]  = '{"lbu_006e", 1'b0, 3'd4, 16'h006e, 32'h0,        32'h1180AB11, 1'b0, 32'h00000080, 32'h1180AB11, 2};
    vt[4]  = '{"lw_006c",  1'b0, 3'd2, 16'h006c, 32'h0,        32'h1180AB11, 1'b0, 32'h1180AB11, 32'h1180AB11, 2};
    vt[5]  = '{"lh_006f",  1'b0, 3'd1, 16'h006f, 32'h0,        32'h1180AB11, 1'b1, 32'h0,        32'h1180AB11, 1};
    vt[6]  = '{"sw_006e",  1'b1, 3'd2, 16'h006e, 32'h55555555, 32'h1180AB11, 1'b1, 32'h0,        32'h1180AB11, 1};
    vt[7]  = '{"f3_011",   1'b0, 3'd3, 16'h0010, 32'h0,        32'h01020304, 1'b1, 32'h0,        32'h01020304, 1};
    vt[8]  = '{"st_bu",    1'b1, 3'd4, 16'h0010, 32'h000000FF, 32'hCAFEF00D, 1'b1, 32'h0,        32'hCAFEF00D, 1};
    vt[9]  = '{"sh_0012",  1'b1, 3'd1, 16'h0012, 32'h0000BEEF, 32'h12345678, 1'b0, 32'h0,        32'hBEEF5678, 3};
    vt[10] = '{"lh_0012",  1'b0, 3'd1, 16'h0012, 32'h0,        32'h80017FFF, 1'b0, 32'hFFFF8001, 32'h80017FFF, 2};
    vt[11] = '{"lhu_0012", 1'b0, 3'd5, 16'h0012, 32'h0,        32'h80017FFF, 1'b0, 32'h00008001, 32'h80017FFF, 2};
    vt[12] = '{"lw_fffc",  1'b0, 3'd2, 16'hFFFC, 32'h0,        32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF, 2};
    vt[13] = '{"sb_ffff",  1'b1, 3'd0, 16'hFFFF, 32'h12345677, 32'h00000000, 1'b0, 32'h0,        32'h77000000, 3};
    vt[14] = '{"lb_0101",  1'b0, 3'd0, 16'h0101, 32'h0,        32'h00007F00, 1'b0, 32'h0000007F, 32'h00007F00, 2};
    vt[15] = '{"lw_0102",  1'b0, 3'd2, 16'h0102, 32'h0,        32'h0000FFFF, 1'b1, 32'h0,        32'h0000FFFF, 1};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 16'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) preset(8'(i), $urandom);
    #1;
    chk("rst req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst mem_wEn", {31'h0, mem_wEn}, 32'd0);
    chk("rst mem_address", {16'h0, mem_address}, 32'd0);
    chk("rst mem_write_data", mem_write_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      preset(vt[i].addr[9:2], vt[i].pre);
      exec(vt[i].name, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd,
           vt[i].err, vt[i].rd, vt[i].word, vt[i].lat);
    end

    // SH aborted by reset while reading: no write, no response, memory intact.
    begin
      int w0; int r0;
      preset(8'h1b, 32'h12345678);
      w0 = wr_cnt; r0 = resp_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 16'h006e;
      req_wdata = 32'h0000AAAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort read addr", {16'h0, mem_address}, 32'h0000006c);
      rst = 1'b0;
      #1;
      chk("abort req_ready", {31'h0, req_ready}, 32'd1);
      chk("abort resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("abort resp_err", {31'h0, resp_err}, 32'd0);
      chk("abort resp_rdata", resp_rdata, 32'd0);
      chk("abort mem_wEn", {31'h0, mem_wEn}, 32'd0);
      chk("abort mem_address", {16'h0, mem_address}, 32'd0);
      chk("abort mem_write_data", mem_write_data, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("abort writes", wr_cnt - w0, 0);
      chk("abort responses", resp_cnt - r0, 0);
      chk("abort mem_word", mem[8'h1b], 32'h12345678);
      exec("lw_after_abort", 1'b0, 3'd2, 16'h006c, 32'h0, 1'b0, 32'h12345678, 32'h12345678, 2);
    end

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
      wd = $urandom;
      model(we, f3, a, wd, mem[a[9:2]], e, r, w, l);
      exec($sformatf("rnd%0d", n), we, f3, a, wd, e, r, w, l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port req_valid  input  1  core presents a memory request.
REQ-004 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port req_addr  input  16  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  32  load result, extended to 32 bits.
REQ-011 SHALL have port resp_err  output  1  misaligned or illegal request, qualified by resp_valid.
REQ-012 SHALL have port mem_wEn  output  1  data_memory write enable.
REQ-013 SHALL have port mem_address  output  16  word-aligned byte address to data_memory.
REQ-014 SHALL have port mem_write_data  output  32  full word to data_memory.
REQ-015 SHALL have port mem_read_data  input  32  data_memory read word, combinational from mem_address.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept when req_valid & req_ready; latch we, funct3, addr, wdata at acceptance.
REQ-018 SHALL flag error when: H/HU with addr[0]=1; W with addr[1:0]!=00; funct3 in {011,110,111}; store with funct3 in {100,101}.
REQ-019 SHALL, on error, go IDLE->RESP, assert resp_err=1 and resp_rdata=0, and never assert mem_wEn.
REQ-020 SHALL perform a load as IDLE->READ->RESP; sample mem_read_data at the READ->RESP edge; latency of 2 cycles from acceptance to resp_valid.
REQ-021 SHALL perform SW as IDLE->WRITE->RESP, with mem_write_data=wdata.
REQ-022 SHALL perform SB/SH as a read-modify-write IDLE->READ->WRITE->RESP: merge wdata[7:0] into byte lane addr[1:0] (or wdata[15:0] into halfword lane addr[1]) of the word sampled in READ; keep the other lanes unchanged.
REQ-023 SHALL assert mem_wEn=1 for exactly one cycle, only in WRITE.
REQ-024 SHALL drive mem_address={addr[15:2],2'b00} in READ and WRITE, and 0 otherwise; SHALL drive mem_write_data=0 outside WRITE.
REQ-025 SHALL extract the load lane from addr[1:0]: B/H sign-extend; BU/HU zero-extend; W passes the word.
REQ-026 SHALL assert resp_valid=1 for exactly one cycle in RESP; resp_err=0 on success; resp_rdata=0 for stores.
REQ-027 SHALL return RESP->IDLE unconditionally; the next request is accepted no earlier than the cycle after RESP, with no back-to-back overlap.
REQ-028 SHALL ignore the request inputs outside IDLE; changes to them mid-operation SHALL NOT affect the transaction in flight.
REQ-029 SHALL store byte address as-is; no address wrap handling beyond 16-bit truncation (0xFFFC word valid).

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wEn=0, mem_address=0, mem_write_data=0, and clear all latched request registers.
REQ-031 SHALL abort any in-flight transaction on rst=0 asynchronously; a partial RMW SHALL NOT issue its write, and SHALL NOT emit resp_valid.
REQ-032 SHALL begin accepting requests on the first rising edge after rst returns to 1.

Verification
REQ-033 Reset: rst=0 mid-operation -> outputs immediately at the REQ-030 values; req_ready=1.
REQ-034 SW addr 0x006c wdata 0x11100011 -> next cycle mem_wEn=1, mem_address=0x006c, mem_write_data=0x11100011; following cycle resp_valid=1, resp_err=0.
REQ-035 SB addr 0x006d wdata 0x000000AB, memory word 0x11100011 -> single write of 0x1110AB11 to 0x006c; resp_valid 3 cycles after acceptance.
REQ-036 LB addr 0x006e, memory word 0x1180AB11 -> resp_rdata=0xFFFFFF80; LBU same address -> 0x00000080; LW 0x006c -> 0x1180AB11.
REQ-037 LH addr 0x006f and SW addr 0x006e -> resp_err=1 one cycle after acceptance, mem_wEn stays 0, memory unchanged.
REQ-038 SH addr 0x006e, rst pulsed low during WRITE-preceding READ -> mem_wEn never asserted, no resp_valid, memory word unchanged.
